// File: rtl/mips_pkg.sv
// mips_pkg: opcode/funct constants, EX op encodings and decode bundle shared by ID and EX.
package mips_pkg;
  localparam logic [5:0] OPC_RTYPE = 6'h00;
  localparam logic [5:0] OPC_J     = 6'h02;
  localparam logic [5:0] OPC_BEQ   = 6'h04;
  localparam logic [5:0] OPC_ADDI  = 6'h08;
  localparam logic [5:0] OPC_LW    = 6'h23;
  localparam logic [5:0] OPC_SW    = 6'h2B;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;
  localparam logic [5:0] EXOP_NOP  = 6'd0;
  localparam logic [5:0] EXOP_ADD  = 6'd1;
  localparam logic [5:0] EXOP_SUB  = 6'd2;
  localparam logic [5:0] EXOP_AND  = 6'd3;
  localparam logic [5:0] EXOP_OR   = 6'd4;
  localparam logic [5:0] EXOP_SLT  = 6'd5;
  localparam logic [5:0] EXOP_ADDI = 6'd6;
  localparam logic [5:0] EXOP_LW   = 6'd7;
  localparam logic [5:0] EXOP_SW   = 6'd8;
  localparam logic [5:0] EXOP_BEQ  = 6'd9;
  localparam logic [5:0] EXOP_J    = 6'd10;
  typedef struct packed {
    logic [5:0]  op;
    logic [4:0]  rd;
    logic        reg_we;
    logic        mem_rd;
    logic        mem_wr;
    logic        uses_rt;
    logic [31:0] imm;
  } dec_t;
  function automatic logic [31:0] sext16(input logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction
endpackage

// File: rtl/mips_regfile.sv
// mips_regfile: 2 comb read ports, 1 sync write port, $0 hardwired to zero.
// MIPS_RF_BYPASS_EN: same-cycle read of the write address returns the write data.
module mips_regfile #(
  parameter int RF_DEPTH = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  addr_a,
  input  logic [4:0]  addr_b,
  output logic [31:0] data_a,
  output logic [31:0] data_b,
  input  logic        we,
  input  logic [4:0]  wa,
  input  logic [31:0] wd
);
  logic [31:0] mem [RF_DEPTH];
  always_ff @(posedge clk or posedge rst)
    if (rst) for (int i = 0; i < RF_DEPTH; i++) mem[i] <= '0;
    else if (we && wa != '0) mem[wa] <= wd;
`ifdef MIPS_RF_BYPASS_EN
  assign data_a = addr_a == '0 ? '0 : (we && wa == addr_a) ? wd : mem[addr_a];
  assign data_b = addr_b == '0 ? '0 : (we && wa == addr_b) ? wd : mem[addr_b];
`else
  assign data_a = addr_a == '0 ? '0 : mem[addr_a];
  assign data_b = addr_b == '0 ? '0 : mem[addr_b];
`endif
endmodule

// File: rtl/mips_decode_stage.sv
// mips_decode_stage: MIPS ID stage - decoder, load-use hazard unit, ID/EX latch.
// MIPS_RF_BYPASS_EN (in mips_regfile) enables WB->ID write-through.
module mips_decode_stage
  import mips_pkg::*;
#(
  parameter int          RF_DEPTH = 32,
  parameter logic [31:0] RESET_PC = '0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_valid,
  input  logic [31:0] if_ir,
  input  logic [31:0] if_npc,
  input  logic        ex_flush,
  input  logic        wb_we,
  input  logic [4:0]  wb_addr,
  input  logic [31:0] wb_data,
  output logic        id_stall,
  output logic        ex_valid,
  output logic [5:0]  ex_op,
  output logic [31:0] ex_npc,
  output logic [31:0] ex_a,
  output logic [31:0] ex_b,
  output logic [31:0] ex_imm,
  output logic [4:0]  ex_rd,
  output logic        ex_reg_we,
  output logic        ex_mem_rd,
  output logic        ex_mem_wr
);
  logic [5:0] opc, fn;
  logic [4:0] rs, rt;
  logic [31:0] data_a, data_b;
  logic bubble;
  dec_t d;
  assign opc = if_ir[31:26];
  assign fn = if_ir[5:0];
  assign rs = if_ir[25:21];
  assign rt = if_ir[20:16];
  mips_regfile #(.RF_DEPTH(RF_DEPTH)) u_rf (
    .clk(clk), .rst(rst), .addr_a(rs), .addr_b(rt), .data_a(data_a), .data_b(data_b),
    .we(wb_we), .wa(wb_addr), .wd(wb_data)
  );
  // rd is only set for writers, so reg_we falls out of rd != 0
  always_comb begin
    d = '0;
    case (opc)
      OPC_RTYPE: begin
        d.op = fn == FN_ADD ? EXOP_ADD : fn == FN_SUB ? EXOP_SUB : fn == FN_AND ? EXOP_AND :
               fn == FN_OR ? EXOP_OR : fn == FN_SLT ? EXOP_SLT : EXOP_NOP;
        d.rd = d.op == EXOP_NOP ? '0 : if_ir[15:11];
        d.uses_rt = d.op != EXOP_NOP;
      end
      OPC_ADDI: begin
        d.op = EXOP_ADDI;
        d.rd = rt;
        d.imm = sext16(if_ir[15:0]);
      end
      OPC_LW: begin
        d.op = EXOP_LW;
        d.rd = rt;
        d.mem_rd = 1'b1;
        d.imm = sext16(if_ir[15:0]);
      end
      OPC_SW: begin
        d.op = EXOP_SW;
        d.mem_wr = 1'b1;
        d.uses_rt = 1'b1;
        d.imm = sext16(if_ir[15:0]);
      end
      OPC_BEQ: begin
        d.op = EXOP_BEQ;
        d.uses_rt = 1'b1;
        d.imm = sext16(if_ir[15:0]);
      end
      OPC_J: begin
        d.op = EXOP_J;
        d.imm = {if_npc[31:28], if_ir[25:0], 2'b00};
      end
      default: ;
    endcase
    d.reg_we = d.rd != '0;
  end
  assign id_stall = if_valid & ~ex_flush & ex_valid & ex_mem_rd & (ex_rd != '0) &
                    ((ex_rd == rs) | ((ex_rd == rt) & d.uses_rt));
  assign bubble = ex_flush | ~if_valid | id_stall;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      ex_valid <= 1'b0;
      ex_op <= EXOP_NOP;
      ex_npc <= RESET_PC;
      ex_a <= '0;
      ex_b <= '0;
      ex_imm <= '0;
      ex_rd <= '0;
      ex_reg_we <= 1'b0;
      ex_mem_rd <= 1'b0;
      ex_mem_wr <= 1'b0;
    end else begin
      ex_valid <= ~bubble;
      ex_op <= bubble ? EXOP_NOP : d.op;
      ex_npc <= if_npc;
      ex_a <= data_a;
      ex_b <= data_b;
      ex_imm <= d.imm;
      ex_rd <= bubble ? '0 : d.rd;
      ex_reg_we <= ~bubble & d.reg_we;
      ex_mem_rd <= ~bubble & d.mem_rd;
      ex_mem_wr <= ~bubble & d.mem_wr;
    end
endmodule

// File: tb/tb_mips_decode_stage.sv
// tb_mips_decode_stage: table vectors, directed hazard/flush/reset sequences and random
// stimulus checked against an instruction-level model of the ID stage.
module tb_mips_decode_stage;
  import mips_pkg::*;
  localparam logic [31:0] RPC = 32'hBFC0_0000;
  logic clk = 0, rst = 1;
  logic if_valid = 0, ex_flush = 0, wb_we = 0;
  logic [31:0] if_ir = 0, if_npc = 0, wb_data = 0;
  logic [4:0] wb_addr = 0;
  logic id_stall, ex_valid, ex_reg_we, ex_mem_rd, ex_mem_wr;
  logic [5:0] ex_op;
  logic [31:0] ex_npc, ex_a, ex_b, ex_imm;
  logic [4:0] ex_rd;
  mips_decode_stage #(.RF_DEPTH(32), .RESET_PC(RPC)) dut (
    .clk(clk), .rst(rst), .if_valid(if_valid), .if_ir(if_ir), .if_npc(if_npc),
    .ex_flush(ex_flush), .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
    .id_stall(id_stall), .ex_valid(ex_valid), .ex_op(ex_op), .ex_npc(ex_npc), .ex_a(ex_a),
    .ex_b(ex_b), .ex_imm(ex_imm), .ex_rd(ex_rd), .ex_reg_we(ex_reg_we),
    .ex_mem_rd(ex_mem_rd), .ex_mem_wr(ex_mem_wr)
  );
  always #5 clk = ~clk;
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  typedef struct packed {
    logic valid;
    logic [5:0] op;
    logic [31:0] a, b, imm, npc;
    logic [4:0] rd;
    logic we, mrd, mwr;
  } lat_t;
  typedef struct packed {
    logic [31:0] ir, npc;
    logic [5:0] op;
    logic [4:0] rd;
    logic [31:0] imm;
    logic we, mrd, mwr;
  } vec_t;
  int passed = 0, total = 0;
  logic [31:0] rf [32];
  lat_t m;
  logic seen_stall;
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", n, act, exp);
  endtask
  function automatic logic [31:0] rtype(input int rs, rt, rd, input logic [5:0] fn);
    return {6'd0, 5'(rs), 5'(rt), 5'(rd), 5'd0, fn};
  endfunction
  function automatic logic [31:0] itype(input logic [5:0] op, input int rs, rt, input logic [15:0] im);
    return {op, 5'(rs), 5'(rt), im};
  endfunction
  // register read as ID sees it, including same-cycle WB write-through when enabled
  function automatic logic [31:0] rd_reg(input logic [4:0] r, input logic we, input logic [4:0] wa, input logic [31:0] wd);
    if (r == 0) return 0;
`ifdef MIPS_RF_BYPASS_EN
    if (we && wa == r) return wd;
`endif
    return rf[r];
  endfunction
  task automatic clear_model();
    for (int i = 0; i < 32; i++) rf[i] = 0;
    m = '0;
    m.npc = RPC;
  endtask
  task automatic check_latch(input string tag);
    chk({tag, " valid"}, 32'(ex_valid), 32'(m.valid));
    chk({tag, " op"}, 32'(ex_op), 32'(m.op));
    chk({tag, " rd"}, 32'(ex_rd), 32'(m.rd));
    chk({tag, " flags"}, {ex_reg_we, ex_mem_rd, ex_mem_wr}, {m.we, m.mrd, m.mwr});
    if (m.valid) begin
      chk({tag, " a"}, ex_a, m.a);
      chk({tag, " b"}, ex_b, m.b);
      chk({tag, " imm"}, ex_imm, m.imm);
      chk({tag, " npc"}, ex_npc, m.npc);
    end
  endtask
  // one ID cycle: drive, check stall, predict the latch from instruction semantics, clock, compare
  task automatic step(input logic v, input logic [31:0] ir, npc, input logic fl, we,
                      input logic [4:0] wa, input logic [31:0] wd);
    lat_t n;
    logic st, src_rt, is_r;
    logic [4:0] rs, rt;
    logic [5:0] fn;
    if_valid = v; if_ir = ir; if_npc = npc; ex_flush = fl;
    wb_we = we; wb_addr = wa; wb_data = wd;
    #1;
    rs = ir[25:21]; rt = ir[20:16]; fn = ir[5:0];
    n = '0;
    n.valid = 1;
    n.npc = npc;
    n.a = rd_reg(rs, we, wa, wd);
    n.b = rd_reg(rt, we, wa, wd);
    n.imm = {{16{ir[15]}}, ir[15:0]};
    is_r = ir[31:26] == 6'h00;
    if (is_r) begin
      n.imm = 0;
      n.op = fn == 6'h20 ? 6'd1 : fn == 6'h22 ? 6'd2 : fn == 6'h24 ? 6'd3 :
             fn == 6'h25 ? 6'd4 : fn == 6'h2A ? 6'd5 : 6'd0;
      if (n.op != 0) n.rd = ir[15:11];
    end else if (ir[31:26] == 6'h08) begin n.op = 6; n.rd = rt; end
    else if (ir[31:26] == 6'h23) begin n.op = 7; n.rd = rt; n.mrd = 1; end
    else if (ir[31:26] == 6'h2B) begin n.op = 8; n.mwr = 1; end
    else if (ir[31:26] == 6'h04) n.op = 9;
    else if (ir[31:26] == 6'h02) begin n.op = 10; n.imm = {npc[31:28], ir[25:0], 2'b00}; end
    else begin n.op = 0; n.imm = 0; end
    n.we = n.rd != 0;
    src_rt = (is_r && n.op != 0) || n.op == 8 || n.op == 9;
    st = v && !fl && m.valid && m.mrd && m.rd != 0 && (m.rd == rs || (m.rd == rt && src_rt));
    seen_stall = id_stall;
    chk("id_stall", 32'(id_stall), 32'(st));
    if (fl || !v || st) begin
      n.valid = 0; n.op = 0; n.rd = 0; n.we = 0; n.mrd = 0; n.mwr = 0;
    end
    @(posedge clk); #1;
    if (we && wa != 0) rf[wa] = wd;
    m = n;
    check_latch("latch");
  endtask
  task automatic wb(input int r, input logic [31:0] d);
    step(0, 0, 0, 0, 1, 5'(r), d);
  endtask
  vec_t tbl [10];
  logic [31:0] cur_ir, cur_npc;
  logic held;
  initial begin
    clear_model();
    repeat (2) @(posedge clk);
    #1;
    chk("reset valid", 32'(ex_valid), 0);
    chk("reset npc", ex_npc, RPC);
    chk("reset op/rd/flags", {ex_op, ex_rd, ex_reg_we, ex_mem_rd, ex_mem_wr}, 0);
    chk("reset data", ex_a | ex_b | ex_imm, 0);
    chk("reset stall", 32'(id_stall), 0);
    @(negedge clk) rst = 0;
    @(posedge clk); #1;
    wb(1, 7); wb(2, 5);
    tbl[0] = '{rtype(1, 2, 3, FN_ADD), 32'h104, EXOP_ADD, 5'd3, 32'h0, 1'b1, 1'b0, 1'b0};
    tbl[1] = '{itype(OPC_ADDI, 1, 4, 16'hFFFE), 32'h108, EXOP_ADDI, 5'd4, 32'hFFFF_FFFE, 1'b1, 1'b0, 1'b0};
    tbl[2] = '{{OPC_J, 26'h040_0000}, 32'h1000_0004, EXOP_J, 5'd0, 32'h1100_0000, 1'b0, 1'b0, 1'b0};
    tbl[3] = '{rtype(1, 2, 5, FN_SUB), 32'h110, EXOP_SUB, 5'd5, 32'h0, 1'b1, 1'b0, 1'b0};
    tbl[4] = '{rtype(1, 2, 0, FN_SLT), 32'h114, EXOP_SLT, 5'd0, 32'h0, 1'b0, 1'b0, 1'b0};
    tbl[5] = '{itype(OPC_LW, 1, 6, 16'h0008), 32'h118, EXOP_LW, 5'd6, 32'h8, 1'b1, 1'b1, 1'b0};
    tbl[6] = '{itype(OPC_SW, 1, 2, 16'hFFFC), 32'h11C, EXOP_SW, 5'd0, 32'hFFFF_FFFC, 1'b0, 1'b0, 1'b1};
    tbl[7] = '{itype(OPC_BEQ, 1, 2, 16'h0010), 32'h120, EXOP_BEQ, 5'd0, 32'h10, 1'b0, 1'b0, 1'b0};
    tbl[8] = '{{6'h3F, 26'h3FF_FFFF}, 32'h124, EXOP_NOP, 5'd0, 32'h0, 1'b0, 1'b0, 1'b0};
    tbl[9] = '{rtype(2, 1, 9, FN_OR), 32'h128, EXOP_OR, 5'd9, 32'h0, 1'b1, 1'b0, 1'b0};
    foreach (tbl[i]) begin
      step(1, tbl[i].ir, tbl[i].npc, 0, 0, 0, 0);
      chk($sformatf("vec%0d op", i), 32'(ex_op), 32'(tbl[i].op));
      chk($sformatf("vec%0d rd", i), 32'(ex_rd), 32'(tbl[i].rd));
      chk($sformatf("vec%0d imm", i), ex_imm, tbl[i].imm);
      chk($sformatf("vec%0d flags", i), {ex_reg_we, ex_mem_rd, ex_mem_wr}, {tbl[i].we, tbl[i].mrd, tbl[i].mwr});
      if (i == 0) chk("vec0 a/b/npc", {ex_a[7:0], ex_b[7:0], ex_npc[15:0]}, 32'h0705_0104);
    end
    // load-use: one stall, one bubble, then the dependent ADD issues
    step(1, itype(OPC_LW, 1, 6, 0), 32'h200, 0, 0, 0, 0);
    step(1, rtype(6, 2, 7, FN_ADD), 32'h204, 0, 0, 0, 0);
    chk("lu stall", 32'(seen_stall), 1);
    chk("lu bubble", 32'(ex_valid), 0);
    step(1, rtype(6, 2, 7, FN_ADD), 32'h204, 0, 0, 0, 0);
    chk("lu release", 32'(seen_stall), 0);
    chk("lu issue", {ex_valid, ex_op, ex_rd}, {1'b1, EXOP_ADD, 5'd7});
    // flush during a would-be stall
    step(1, itype(OPC_LW, 1, 6, 0), 32'h300, 0, 0, 0, 0);
    step(1, rtype(6, 2, 7, FN_ADD), 32'h304, 1, 0, 0, 0);
    chk("fl stall", 32'(seen_stall), 0);
    chk("fl bubble", {ex_valid, ex_reg_we}, 0);
    step(1, itype(OPC_ADDI, 0, 10, 1), 32'h400, 0, 0, 0, 0);
    chk("fl no dup", {ex_valid, ex_op, ex_rd}, {1'b1, EXOP_ADDI, 5'd10});
    // WB->ID same-cycle read, and writes to $0
    wb(8, 32'h1111);
    step(1, rtype(8, 0, 9, FN_ADD), 32'h500, 0, 1, 8, 32'hDEAD);
`ifdef MIPS_RF_BYPASS_EN
    chk("wb bypass a", ex_a, 32'hDEAD);
`else
    chk("wb old a", ex_a, 32'h1111);
`endif
    step(1, rtype(0, 0, 9, FN_ADD), 32'h504, 0, 1, 0, 32'h123);
    chk("r0 same", ex_a | ex_b, 0);
    step(1, rtype(0, 8, 9, FN_ADD), 32'h508, 0, 0, 0, 0);
    chk("r0 after", ex_a, 0);
    chk("r8 after", ex_b, 32'hDEAD);
    // random traffic; a stalled instruction is re-presented, as IF/ID would hold it
    held = 0;
    for (int i = 0; i < 600; i++) begin
      if (!held) begin
        int k, a, b, c;
        k = $urandom_range(0, 9); a = $urandom_range(0, 7); b = $urandom_range(0, 7); c = $urandom_range(0, 7);
        cur_npc = $urandom & 32'hFFFF_FFFC;
        case (k)
          0: cur_ir = rtype(a, b, c, FN_ADD);
          1: cur_ir = rtype(a, b, c, ($urandom_range(0, 1) == 0) ? FN_SUB : FN_SLT);
          2: cur_ir = rtype(a, b, c, ($urandom_range(0, 1) == 0) ? FN_AND : 6'h3);
          3: cur_ir = itype(OPC_ADDI, a, b, 16'($urandom));
          4, 5: cur_ir = itype(OPC_LW, a, b, 16'($urandom));
          6: cur_ir = itype(OPC_SW, a, b, 16'($urandom));
          7: cur_ir = itype(OPC_BEQ, a, b, 16'($urandom));
          8: cur_ir = {OPC_J, 26'($urandom)};
          default: cur_ir = {6'h3D, 26'($urandom)};
        endcase
      end
      if (i == 300) begin
        @(negedge clk); #3 rst = 1;
        #1;
        clear_model();
        chk("midrun rst valid", 32'(ex_valid), 0);
        chk("midrun rst npc", ex_npc, RPC);
        if_ir = rtype(5, 5, 0, FN_ADD); if_valid = 0; ex_flush = 0; wb_we = 0;
        #1;
        chk("midrun rf5", dut.u_rf.data_a, 0);
        @(negedge clk) rst = 0;
        @(posedge clk); #1;
        check_latch("post rst");
        held = 0;
      end
      step($urandom_range(0, 9) != 0, cur_ir, cur_npc, $urandom_range(0, 9) == 0,
           $urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)), $urandom);
      held = seen_stall;
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
